star_hide_sequencer: RTL

- Goal-seeking successor to the star hiding state machine; press hides the star, pull shows it.
- Drives the grill motor and star motor through the required order: open grill, move star, close grill.
- Adds input debounce, per-motion watchdog timeout, sensor-validity and interlock faults, a settle dead-time between motions, and a selectable hold-to-run or automatic mode.
- Sits between the front-panel buttons/position sensors and the motor driver stage.

---
 rtl/star_hide_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/star_hide_sequencer.sv
// Star hide/show sequencer: debounced commands drive grill and star motors in the
// order open grill, move star, close grill, with watchdog, interlock and sensor faults.
module star_hide_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int SETTLE_CYCLES   = 2,
  parameter int AUTO_MODE       = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_press,
  input  logic       i_pull,
  input  logic [1:0] i_grill_pos,
  input  logic [1:0] i_star_pos,
  input  logic       i_fault_clr,
  output logic [3:0] o_output,
  output logic [2:0] o_state,
  output logic       o_busy,
  output logic       o_fault,
  output logic [1:0] o_fault_code
);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_G_OPEN    = 3'd2,
    ST_G_CLOSE   = 3'd3,
    ST_S_RETRACT = 3'd4,
    ST_S_EXTEND  = 3'd5,
    ST_SETTLE    = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_HIDE = 2'd1,
    TGT_SHOW = 2'd2
  } tgt_t;

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] ST_LAST = 16'(SETTLE_CYCLES - 1);

  localparam logic [1:0] FC_TIMEOUT   = 2'b01;
  localparam logic [1:0] FC_INVALID   = 2'b10;
  localparam logic [1:0] FC_INTERLOCK = 2'b11;

  // Command debounce: a raw value must disagree for DEBOUNCE_CYCLES clocks to be taken.
  logic       press_db, pull_db;
  logic [7:0] press_cnt, pull_cnt;
  logic       press_flip, pull_flip, press_rise, pull_rise;

  assign press_flip = (i_press != press_db) && (press_cnt == DB_LAST);
  assign pull_flip  = (i_pull != pull_db) && (pull_cnt == DB_LAST);
  assign press_rise = press_flip && i_press;
  assign pull_rise  = pull_flip && i_pull;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      press_db  <= 1'b0;
      pull_db   <= 1'b0;
      press_cnt <= '0;
      pull_cnt  <= '0;
    end else begin
      if (i_press == press_db) begin
        press_cnt <= '0;
      end else if (press_flip) begin
        press_db  <= i_press;
        press_cnt <= '0;
      end else begin
        press_cnt <= press_cnt + 8'd1;
      end
      if (i_pull == pull_db) begin
        pull_cnt <= '0;
      end else if (pull_flip) begin
        pull_db  <= i_pull;
        pull_cnt <= '0;
      end else begin
        pull_cnt <= pull_cnt + 8'd1;
      end
    end
  end

  state_t      state_q, dec_state;
  tgt_t        tgt_q, run_tgt_q, tgt;
  logic [15:0] tmr_q;
  logic [1:0]  code_q;
  logic        sensor_bad, end_hit, star_move;

  function automatic state_t decide(input tgt_t t, input logic [1:0] g, input logic [1:0] s);
    logic [1:0] goal;
    state_t     smove;
    goal  = (t == TGT_HIDE) ? 2'b01 : 2'b00;
    smove = (t == TGT_HIDE) ? ST_S_RETRACT : ST_S_EXTEND;
    if (t == TGT_NONE)                 return ST_IDLE;
    else if (s == goal && g == 2'b00)  return ST_IDLE;
    else if (s == goal)                return ST_G_CLOSE;
    else if (g == 2'b01)               return smove;
    else                               return ST_G_OPEN;
  endfunction

  // Hold-to-run follows the debounced buttons directly; automatic mode latches edges.
  always_comb begin
    tgt = tgt_q;
    if (AUTO_MODE == 0) begin
      if (press_db && !pull_db)      tgt = TGT_HIDE;
      else if (pull_db && !press_db) tgt = TGT_SHOW;
      else                           tgt = TGT_NONE;
    end
  end

  assign sensor_bad = (i_grill_pos == 2'b11) || (i_star_pos == 2'b11);
  assign star_move  = (state_q == ST_S_RETRACT) || (state_q == ST_S_EXTEND);
  assign dec_state  = decide(tgt, i_grill_pos, i_star_pos);

  always_comb begin
    end_hit = 1'b0;
    case (state_q)
      ST_G_OPEN:    end_hit = (i_grill_pos == 2'b01);
      ST_G_CLOSE:   end_hit = (i_grill_pos == 2'b00);
      ST_S_RETRACT: end_hit = (i_star_pos == 2'b01);
      ST_S_EXTEND:  end_hit = (i_star_pos == 2'b00);
      default:      end_hit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_INIT;
      tgt_q     <= TGT_NONE;
      run_tgt_q <= TGT_NONE;
      tmr_q     <= '0;
      code_q    <= 2'b00;
    end else begin
      if (press_rise && pull_rise) tgt_q <= TGT_NONE;
      else if (press_rise)         tgt_q <= TGT_HIDE;
      else if (pull_rise)          tgt_q <= TGT_SHOW;

      case (state_q)
        ST_INIT: begin
          if (sensor_bad) begin
            state_q <= ST_FAULT;
            code_q  <= FC_INVALID;
            tgt_q   <= TGT_NONE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE, ST_SETTLE: begin
          if (sensor_bad) begin
            state_q <= ST_FAULT;
            code_q  <= FC_INVALID;
            tgt_q   <= TGT_NONE;
          end else if (state_q == ST_SETTLE && tmr_q != ST_LAST) begin
            tmr_q <= tmr_q + 16'd1;
          end else begin
            state_q   <= dec_state;
            run_tgt_q <= tgt;
            tmr_q     <= '0;
            if (tgt != TGT_NONE && dec_state == ST_IDLE) tgt_q <= TGT_NONE;
          end
        end
        ST_G_OPEN, ST_G_CLOSE, ST_S_RETRACT, ST_S_EXTEND: begin
          if (sensor_bad) begin
            state_q <= ST_FAULT;
            code_q  <= FC_INVALID;
            tgt_q   <= TGT_NONE;
          end else if (star_move && i_grill_pos != 2'b01) begin
            state_q <= ST_FAULT;
            code_q  <= FC_INTERLOCK;
            tgt_q   <= TGT_NONE;
          end else if (end_hit) begin
            state_q <= ST_SETTLE;
            tmr_q   <= '0;
          end else if (tmr_q == TO_LAST) begin
            state_q <= ST_FAULT;
            code_q  <= FC_TIMEOUT;
            tgt_q   <= TGT_NONE;
          end else if (tgt != run_tgt_q) begin
            state_q <= ST_SETTLE;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        ST_FAULT: begin
          tgt_q <= TGT_NONE;
          if (i_fault_clr) begin
            state_q <= ST_INIT;
            code_q  <= 2'b00;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Drives decode straight from the state register so reset drops them at once.
  always_comb begin
    o_output = 4'b0000;
    case (state_q)
      ST_G_OPEN:    o_output = 4'b1000;
      ST_G_CLOSE:   o_output = 4'b0100;
      ST_S_RETRACT: o_output = 4'b0010;
      ST_S_EXTEND:  o_output = 4'b0001;
      default:      o_output = 4'b0000;
    endcase
  end

  assign o_state      = state_q;
  assign o_busy       = (state_q == ST_G_OPEN) || (state_q == ST_G_CLOSE) || star_move ||
                        (state_q == ST_SETTLE);
  assign o_fault      = (state_q == ST_FAULT);
  assign o_fault_code = code_q;

endmodule
